// File: rtl/alu_station_if.sv
// Opcode encodings shared by the ALU reservation station and its users,
// plus the bundled port interface of the station.
//
// alu_station_if groups the decoder issue port, the CDB wakeup input, the
// CDB output with its arbiter grant, and the occupancy count.
//   master : decoder / CDB side (drives issue, wakeup and grant)
//   slave  : the station itself
package alu_station_pkg;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_AUIPC = 4'd11;
  localparam logic [3:0] OP_JAL   = 4'd12;
  localparam logic [3:0] OP_JALR  = 4'd13;
endpackage

interface alu_station_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int LOCK_W = 5,
  parameter int OP_W   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              issue_valid;
  logic [OP_W-1:0]   issue_op;
  logic [LOCK_W-1:0] issue_rd_lock;
  logic [LOCK_W-1:0] issue_lock1;
  logic [LOCK_W-1:0] issue_lock2;
  logic [DATA_W-1:0] issue_data1;
  logic [DATA_W-1:0] issue_data2;
  logic              issue_ready;
  logic [LOCK_W-1:0] cdb_in_index;
  logic [DATA_W-1:0] cdb_in_result;
  logic              grnt;
  logic              cdb_out_valid;
  logic [LOCK_W-1:0] cdb_out_index;
  logic [DATA_W-1:0] cdb_out_result;
  logic [CNT_W-1:0]  occupancy;

  modport master (
    output issue_valid, issue_op, issue_rd_lock, issue_lock1, issue_lock2,
           issue_data1, issue_data2, cdb_in_index, cdb_in_result, grnt,
    input  issue_ready, cdb_out_valid, cdb_out_index, cdb_out_result, occupancy
  );

  modport slave (
    input  issue_valid, issue_op, issue_rd_lock, issue_lock1, issue_lock2,
           issue_data1, issue_data2, cdb_in_index, cdb_in_result, grnt,
    output issue_ready, cdb_out_valid, cdb_out_index, cdb_out_result, occupancy
  );
endinterface

// File: rtl/alu_station.sv
// ALU reservation station: holds up to DEPTH issued operations until both
// source operands are available (captured directly or snooped from the CDB),
// then dispatches the oldest ready one through the ALU into a registered
// CDB output stage that holds until granted.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset (dominates flush and issue)
//   flush : synchronous clear of all entries and the output stage
//   bus   : alu_station_if.slave (issue, CDB in, CDB out + grnt, occupancy)
module alu_station
  import alu_station_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int LOCK_W = 5,
  parameter int OP_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  alu_station_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int SH_W  = $clog2(DATA_W);

  // Entry storage
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [OP_W-1:0]   op_d    [DEPTH];
  logic [LOCK_W-1:0] rd_q    [DEPTH];
  logic [LOCK_W-1:0] rd_d    [DEPTH];
  logic [LOCK_W-1:0] lock1_q [DEPTH];
  logic [LOCK_W-1:0] lock1_d [DEPTH];
  logic [LOCK_W-1:0] lock2_q [DEPTH];
  logic [LOCK_W-1:0] lock2_d [DEPTH];
  logic [DATA_W-1:0] data1_q [DEPTH];
  logic [DATA_W-1:0] data1_d [DEPTH];
  logic [DATA_W-1:0] data2_q [DEPTH];
  logic [DATA_W-1:0] data2_d [DEPTH];
  // older_q[i][j] = 1 when entry i was issued before entry j
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];

  // Output stage
  logic              out_valid_q, out_valid_d;
  logic [LOCK_W-1:0] out_index_q, out_index_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;

  logic [CNT_W-1:0]  occ;
  logic [DEPTH-1:0]  rdy_vec;
  logic [DEPTH-1:0]  sel_oh;
  logic              blocked;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  free_idx;
  logic              any_rdy;
  logic              out_free;
  logic              dispatch;
  logic              issue_acc;
  logic              store;

  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [SH_W-1:0]          sh;
    logic [DATA_W-1:0]        sum;
    logic [DATA_W-1:0]        r;
    sa  = a;
    sb  = b;
    sh  = b[SH_W-1:0];
    sum = a + b;
    case (op)
      OP_ADD:   r = sum;
      OP_SUB:   r = a - b;
      OP_SLT:   r = {{(DATA_W-1){1'b0}}, (sa < sb)};
      OP_SLTU:  r = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_XOR:   r = a ^ b;
      OP_OR:    r = a | b;
      OP_AND:   r = a & b;
      OP_SLL:   r = a << sh;
      OP_SRL:   r = a >> sh;
      OP_SRA:   r = sa >>> sh;
      OP_AUIPC: r = sum;
      OP_JAL:   r = sum;
      OP_JALR:  r = {sum[DATA_W-1:1], 1'b0};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Selection: ready vector, oldest-ready pick and first free slot, all
  // from registered state so a wakeup only becomes selectable next cycle.
  always_comb begin
    occ      = '0;
    rdy_vec  = '0;
    sel_oh   = '0;
    blocked  = 1'b0;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ        = occ + CNT_W'(valid_q[i]);
      rdy_vec[i] = valid_q[i] && (lock1_q[i] == '0) && (lock2_q[i] == '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (rdy_vec[j] && older_q[j][i]) blocked = 1'b1;
      end
      sel_oh[i] = rdy_vec[i] && !blocked;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign any_rdy   = |rdy_vec;
  assign out_free  = !out_valid_q || bus.grnt;
  assign dispatch  = out_free && any_rdy && !flush;
  assign issue_acc = bus.issue_valid && bus.issue_ready && !flush;
  assign store     = issue_acc && (bus.issue_op != OP_W'(OP_NOP));

  // Next state: dispatch, wakeup, issue (with same-edge bypass), flush
  always_comb begin
    valid_d      = valid_q;
    op_d         = op_q;
    rd_d         = rd_q;
    lock1_d      = lock1_q;
    lock2_d      = lock2_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    older_d      = older_q;
    out_valid_d  = out_valid_q;
    out_index_d  = out_index_q;
    out_result_d = out_result_q;

    if (dispatch) begin
      valid_d[sel_idx] = 1'b0;
      out_valid_d      = 1'b1;
      out_index_d      = rd_q[sel_idx];
      out_result_d     = alu_calc(op_q[sel_idx], data1_q[sel_idx], data2_q[sel_idx]);
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end

    if (bus.cdb_in_index != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && lock1_q[i] == bus.cdb_in_index) begin
          lock1_d[i] = '0;
          data1_d[i] = bus.cdb_in_result;
        end
        if (valid_q[i] && lock2_q[i] == bus.cdb_in_index) begin
          lock2_d[i] = '0;
          data2_d[i] = bus.cdb_in_result;
        end
      end
    end

    if (store) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = bus.issue_op;
      rd_d[free_idx]    = bus.issue_rd_lock;
      if (bus.cdb_in_index != '0 && bus.issue_lock1 == bus.cdb_in_index) begin
        lock1_d[free_idx] = '0;
        data1_d[free_idx] = bus.cdb_in_result;
      end else begin
        lock1_d[free_idx] = bus.issue_lock1;
        data1_d[free_idx] = bus.issue_data1;
      end
      if (bus.cdb_in_index != '0 && bus.issue_lock2 == bus.cdb_in_index) begin
        lock2_d[free_idx] = '0;
        data2_d[free_idx] = bus.cdb_in_result;
      end else begin
        lock2_d[free_idx] = bus.issue_lock2;
        data2_d[free_idx] = bus.issue_data2;
      end
      // New entry is youngest: every currently valid entry is older than it.
      // Bits left behind by entries dispatched this edge are harmless since
      // selection masks them with valid.
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        older_d[j][free_idx] = valid_q[j];
      end
    end

    if (flush) begin
      valid_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  // Control state and output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_result_q <= '0;
    end else begin
      valid_q      <= valid_d;
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      out_result_q <= out_result_d;
    end
  end

  // Entry payload, qualified by valid_q
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    rd_q    <= rd_d;
    lock1_q <= lock1_d;
    lock2_q <= lock2_d;
    data1_q <= data1_d;
    data2_q <= data2_d;
    older_q <= older_d;
  end

  assign bus.issue_ready    = (occ != CNT_W'(DEPTH));
  assign bus.occupancy      = occ;
  assign bus.cdb_out_valid  = out_valid_q;
  assign bus.cdb_out_index  = out_index_q;
  assign bus.cdb_out_result = out_result_q;

endmodule

// File: tb/tb_alu_station.sv
// Scoreboard bench for alu_station: a queue-based reference model of the
// station advances on every rising edge and pushes expected CDB results;
// a monitor on the falling edge checks handshake/occupancy every cycle and
// pops/compares each result as it is granted.
module tb_alu_station;
  import alu_station_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic [31:0] d1;
    logic [31:0] d2;
  } ent_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  alu_station_if #(.DEPTH(DEPTH), .DATA_W(32), .LOCK_W(5), .OP_W(4)) bus ();

  alu_station #(.DEPTH(DEPTH), .DATA_W(32), .LOCK_W(5), .OP_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 0;

  ent_t ent_q[$];
  exp_t exp_q[$];
  logic        m_out_valid = 1'b0;
  logic [4:0]  m_out_idx   = '0;
  logic [31:0] m_out_res   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference ALU from the instruction definitions
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd4:  return {31'd0, a < b};
      4'd5:  return a ^ b;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd8:  return a * (32'd1 << sh);
      4'd9:  return a / (32'd1 << sh);
      4'd10: return a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
      4'd11: return a + b;
      4'd12: return a + b;
      4'd13: return (a + b) & ~32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: age-ordered queue of waiting operations
  task automatic model_step();
    int   k;
    int   sz0;
    logic fr;
    ent_t e;
    exp_t x;
    sz0 = ent_q.size();
    if (rst || flush) begin
      if (m_out_valid && !bus.grnt && exp_q.size() > 0) void'(exp_q.pop_back());
      ent_q.delete();
      m_out_valid = 1'b0;
      if (rst) begin
        m_out_idx = '0;
        m_out_res = '0;
      end
    end else begin
      fr = !m_out_valid || bus.grnt;
      k  = -1;
      for (int i = 0; i < ent_q.size(); i++)
        if (k < 0 && ent_q[i].l1 == 0 && ent_q[i].l2 == 0) k = i;
      if (fr) begin
        if (k >= 0) begin
          m_out_valid = 1'b1;
          m_out_idx   = ent_q[k].rd;
          m_out_res   = ref_alu(ent_q[k].op, ent_q[k].d1, ent_q[k].d2);
          x.idx = m_out_idx;
          x.res = m_out_res;
          exp_q.push_back(x);
          ent_q.delete(k);
        end else begin
          m_out_valid = 1'b0;
        end
      end
      if (bus.cdb_in_index != 0) begin
        foreach (ent_q[i]) begin
          if (ent_q[i].l1 == bus.cdb_in_index) begin ent_q[i].l1 = 0; ent_q[i].d1 = bus.cdb_in_result; end
          if (ent_q[i].l2 == bus.cdb_in_index) begin ent_q[i].l2 = 0; ent_q[i].d2 = bus.cdb_in_result; end
        end
      end
      if (bus.issue_valid && sz0 != DEPTH && bus.issue_op != 4'd0) begin
        e.op = bus.issue_op;
        e.rd = bus.issue_rd_lock;
        e.l1 = bus.issue_lock1;
        e.l2 = bus.issue_lock2;
        e.d1 = bus.issue_data1;
        e.d2 = bus.issue_data2;
        if (bus.cdb_in_index != 0 && e.l1 == bus.cdb_in_index) begin e.l1 = 0; e.d1 = bus.cdb_in_result; end
        if (bus.cdb_in_index != 0 && e.l2 == bus.cdb_in_index) begin e.l2 = 0; e.d2 = bus.cdb_in_result; end
        ent_q.push_back(e);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor
  initial forever begin
    exp_t x;
    @(negedge clk);
    if (chk_en) begin
      chk("out_valid", {31'd0, bus.cdb_out_valid}, {31'd0, m_out_valid});
      chk("issue_ready", {31'd0, bus.issue_ready}, {31'd0, ent_q.size() != DEPTH});
      chk("occupancy", 32'(bus.occupancy), 32'(ent_q.size()));
      if (bus.cdb_out_valid && bus.grnt) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          x = exp_q.pop_front();
          chk("sb_index", 32'(bus.cdb_out_index), 32'(x.idx));
          chk("sb_result", bus.cdb_out_result, x.res);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_op      = '0;
    bus.issue_rd_lock = '0;
    bus.issue_lock1   = '0;
    bus.issue_lock2   = '0;
    bus.issue_data1   = '0;
    bus.issue_data2   = '0;
    bus.cdb_in_index  = '0;
    bus.cdb_in_result = '0;
  endtask

  task automatic iss(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] l1,
                     input logic [4:0] l2, input logic [31:0] d1, input logic [31:0] d2);
    bus.issue_valid   = 1'b1;
    bus.issue_op      = op;
    bus.issue_rd_lock = rd;
    bus.issue_lock1   = l1;
    bus.issue_lock2   = l2;
    bus.issue_data1   = d1;
    bus.issue_data2   = d2;
  endtask

  // Issue one ready op with grant held; result must appear one cycle later
  task automatic one_shot(input string name, input logic [3:0] op, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] res);
    iss(op, rd, 0, 0, d1, d2);
    step();
    idle();
    step();
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, bus.cdb_out_valid}, 32'd1);
    chk({name, "_index"}, 32'(bus.cdb_out_index), 32'(rd));
    chk({name, "_result"}, bus.cdb_out_result, res);
  endtask

  task automatic drain();
    int c;
    bus.grnt = 1'b1;
    c = 0;
    while (c < 300 && (ent_q.size() != 0 || m_out_valid)) begin
      bus.cdb_in_index  = 5'(c % 7 + 1);
      bus.cdb_in_result = $urandom;
      step();
      c++;
    end
    idle();
    n_total++;
    if (ent_q.size() != 0 || m_out_valid) begin
      n_bad++;
      $display("FAIL drain_timeout: entries=%0d out_valid=%0b after %0d cycles", ent_q.size(), m_out_valid, c);
    end
    step();
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return 32'($urandom_range(0, 40));
    endcase
  endfunction

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    bus.grnt = 1'b1;
    idle();
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.cdb_out_valid}, 32'd0);
    chk("rst_out_index", 32'(bus.cdb_out_index), 32'd0);
    chk("rst_out_result", bus.cdb_out_result, 32'd0);
    chk("rst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    rst = 1'b0;
    chk_en = 1;
    step();

    // Basic add and edge-case operations
    one_shot("add", OP_ADD, 5'd3, 32'd5, 32'd7, 32'd12);
    one_shot("sra", OP_SRA, 5'd7, 32'h8000_0000, 32'h24, 32'hF800_0000);
    one_shot("jalr", OP_JALR, 5'd8, 32'h1001, 32'd2, 32'h1002);
    one_shot("sltu", OP_SLTU, 5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
    one_shot("unknown_op", 4'd15, 5'd10, 32'd3, 32'd4, 32'd0);
    drain();

    // Fill with entries waiting on tag 9, then release them all at once
    for (int i = 0; i < 4; i++) begin
      iss(OP_ADD, 5'(10 + i), 5'd9, 5'd0, 32'd0, 32'(i));
      step();
    end
    idle();
    @(negedge clk);
    chk("full_issue_ready", {31'd0, bus.issue_ready}, 32'd0);
    chk("full_occupancy", 32'(bus.occupancy), 32'd4);
    bus.cdb_in_index  = 5'd9;
    bus.cdb_in_result = 32'h10;
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("wake_valid", {31'd0, bus.cdb_out_valid}, 32'd1);
      chk("wake_index", 32'(bus.cdb_out_index), 32'(10 + k));
      chk("wake_result", bus.cdb_out_result, 32'h10 + 32'(k));
    end
    drain();

    // Same-edge bypass from the CDB
    iss(OP_SUB, 5'd4, 5'd6, 5'd0, 32'd0, 32'd8);
    bus.cdb_in_index  = 5'd6;
    bus.cdb_in_result = 32'd20;
    step();
    idle();
    step();
    @(negedge clk);
    chk("bypass_valid", {31'd0, bus.cdb_out_valid}, 32'd1);
    chk("bypass_index", 32'(bus.cdb_out_index), 32'd4);
    chk("bypass_result", bus.cdb_out_result, 32'd12);
    drain();

    // Output stall with two ready entries behind it
    bus.grnt = 1'b0;
    iss(OP_ADD, 5'd21, 0, 0, 32'd1, 32'd1);
    step();
    iss(OP_ADD, 5'd22, 0, 0, 32'd2, 32'd2);
    step();
    iss(OP_ADD, 5'd23, 0, 0, 32'd3, 32'd3);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_index", 32'(bus.cdb_out_index), 32'd21);
      chk("stall_result", bus.cdb_out_result, 32'd2);
      step();
    end
    bus.grnt = 1'b1;
    step();
    @(negedge clk);
    chk("nobubble_valid", {31'd0, bus.cdb_out_valid}, 32'd1);
    chk("nobubble_index", 32'(bus.cdb_out_index), 32'd22);
    drain();

    // Flush with entries waiting and an ungranted output
    bus.grnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iss(OP_ADD, 5'(1 + i), 0, 0, 32'(i), 32'd1);
      step();
    end
    idle();
    @(negedge clk);
    chk("preflush_occupancy", 32'(bus.occupancy), 32'd3);
    chk("preflush_valid", {31'd0, bus.cdb_out_valid}, 32'd1);
    flush = 1'b1;
    iss(OP_ADD, 5'd5, 0, 0, 32'd1, 32'd1);
    step();
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_occupancy", 32'(bus.occupancy), 32'd0);
    chk("flush_valid", {31'd0, bus.cdb_out_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("flush_issue_dropped", 32'(bus.occupancy), 32'd0);

    // NOP is accepted and dropped
    bus.grnt = 1'b1;
    iss(OP_NOP, 5'd6, 0, 0, 32'd1, 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("nop_occupancy", 32'(bus.occupancy), 32'd0);
    drain();

    // Randomized traffic including flush and mid-operation reset
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 79) == 0);
      bus.grnt          = ($urandom_range(0, 3) != 0);
      bus.issue_valid   = $urandom_range(0, 1) == 1;
      bus.issue_op      = 4'($urandom_range(0, 15));
      bus.issue_rd_lock = 5'($urandom_range(1, 31));
      bus.issue_lock1   = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
      bus.issue_lock2   = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
      bus.issue_data1   = rnd_data();
      bus.issue_data2   = rnd_data();
      bus.cdb_in_index  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
      bus.cdb_in_result = rnd_data();
      step();
    end
    rst   = 1'b0;
    flush = 1'b0;
    idle();
    drain();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_station.md
ALU_STATION -- requirements
Module: alu_station

Interface
REQ-001 Parameter DEPTH, default 4, number of station entries; power of two, >= 2.
REQ-002 Parameter DATA_W, default 32, operand/result width.
REQ-003 Parameter LOCK_W, default 5, rename-tag width; tag value 0 means "no lock".
REQ-004 Parameter OP_W, default 4, opcode width; encodings from the shared defines file, NOP = 0.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  synchronous clear of all entries and the output stage.
REQ-008 issue_valid  in  1  issue request from decoder.
REQ-009 issue_op  in  OP_W  operation.
REQ-010 issue_rd_lock  in  LOCK_W  destination tag.
REQ-011 issue_lock1 / issue_lock2  in  LOCK_W each  source tags; 0 = operand present.
REQ-012 issue_data1 / issue_data2  in  DATA_W each  source operand values.
REQ-013 issue_ready  out  1  station can accept an issue this cycle.
REQ-014 cdb_in_index  in  LOCK_W  broadcast tag; 0 = no broadcast.
REQ-015 cdb_in_result  in  DATA_W  broadcast value.
REQ-016 grnt  in  1  CDB arbiter grant for cdb_out.
REQ-017 cdb_out_valid  out  1  registered result pending on CDB.
REQ-018 cdb_out_index  out  LOCK_W  registered destination tag.
REQ-019 cdb_out_result  out  DATA_W  registered result.
REQ-020 occupancy  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-021 Issue accepted at an edge iff issue_valid && issue_ready && !flush; written into any free entry, stamped as youngest.
REQ-022 issue_ready = (occupancy != DEPTH), driven from registers only; an entry freed at the same edge does not raise issue_ready in that cycle.
REQ-023 Wakeup: at each edge with cdb_in_index != 0, every valid entry whose lock1/lock2 equals cdb_in_index clears that lock and captures cdb_in_result.
REQ-024 Bypass: an accepted issue whose issue_lockN equals a nonzero cdb_in_index at the same edge is stored with lockN = 0 and dataN = cdb_in_result.
REQ-025 Entry ready = valid && lock1 == 0 && lock2 == 0; selection picks the oldest ready entry; an entry woken at an edge is selectable the following cycle.
REQ-026 Output stage free = !cdb_out_valid || grnt; when free and a ready entry exists, the edge loads the computed result, tag and valid=1 into the output registers and frees the selected entry.
REQ-027 When free and no ready entry exists, the edge clears cdb_out_valid.
REQ-028 While cdb_out_valid && !grnt, cdb_out_index/cdb_out_result hold stable and no entry dispatches.
REQ-029 Latency: issue with both operands present accepted at edge E, output stage free, no older ready entry -> cdb_out_valid high after edge E+1.
REQ-030 Ops (DATA_W-bit, wrap-around): ADD, SUB, SLT signed, SLTU unsigned (result 1/0), XOR, OR, AND, SLL, SRL, SRA (shift amount = low log2(DATA_W) bits of data2), AUIPC = data1 + data2, JAL = data1 + data2, JALR = (data1 + data2) with bit 0 cleared; unknown op -> result 0.
REQ-031 Entries with op NOP are never stored; NOP issue is accepted and dropped.
REQ-032 Flush clears every entry valid bit and cdb_out_valid at the edge; issue and dispatch at that edge are discarded.
REQ-033 Age order is preserved across any interleaving of issue and dispatch, including full-to-empty cycling.

Reset
REQ-034 rst dominates flush and issue; at the edge: all entries invalid, occupancy = 0, cdb_out_valid = 0, cdb_out_index = 0, cdb_out_result = 0, issue_ready = 1 after the edge.
REQ-035 Reset asserted mid-operation discards all pending entries and any ungranted output.

Verification
REQ-036 Issue ADD data1=5, data2=7, locks 0, rd_lock=3, grnt=1 -> cdb_out_valid=1, index=3, result=12 one cycle after acceptance.
REQ-037 Fill DEPTH=4 entries all waiting on tag 9 -> issue_ready=0, occupancy=4; broadcast tag 9 value 0x10 -> all four dispatch in issue order on consecutive cycles with grnt held 1.
REQ-038 Issue SUB lock1=6 in the same cycle cdb_in_index=6, result=20, data2=8 -> output result=12, no extra broadcast needed.
REQ-039 Output valid with grnt=0 for 3 cycles while two ready entries wait -> output stable 3 cycles; on grnt, next-oldest result appears the following cycle with no bubble.
REQ-040 SRA data1=0x80000000, data2=0x24 -> 0xF8000000; JALR data1=0x1001, data2=2 -> 0x1002; SLTU 0xFFFFFFFF vs 1 -> 0.
REQ-041 Flush with 3 entries and output valid -> occupancy=0, cdb_out_valid=0 next cycle; issue asserted at the flush edge is not stored.
